// File: rtl/spike_cmd_uart_tx.sv
// Spike generator command encoder: formats width/freq/count commands
// and ships them as 8N1 UART frames with idle gaps between bytes.
module spike_cmd_uart_tx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200,
  parameter int GAP_BITS = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [5:0] pulse_width,
  input  logic [5:0] freq_sel,
  input  logic [5:0] pulse_cnt,
  input  logic [2:0] send_mask,
  output logic       uart_txd,
  output logic       busy,
  output logic       done
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam int GW = $clog2(GAP_BITS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_GAP,
    S_DONE
  } state_t;

  state_t      state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]  idx, idx_n;
  logic [GW-1:0] gap, gap_n;
  logic [2:0]  mask, mask_n;
  logic [5:0]  w_r, w_n;
  logic [5:0]  f_r, f_n;
  logic [5:0]  c_r, c_n;
  logic [7:0]  sh, sh_n;
  logic        txd_n, busy_n, done_n;
  logic        bit_end;

  // Lowest set mask bit wins: width, then freq, then count.
  function automatic logic [7:0] pick(
    input logic [2:0] m,
    input logic [5:0] w,
    input logic [5:0] f,
    input logic [5:0] c
  );
    if (m[0])      pick = {2'b01, w};
    else if (m[1]) pick = {2'b10, f};
    else           pick = {2'b11, c};
  endfunction

  assign bit_end = (cnt == CW'(BAUD_DIV - 1));

  always_comb begin
    state_n = state;
    idx_n   = idx;
    gap_n   = gap;
    mask_n  = mask;
    w_n     = w_r;
    f_n     = f_r;
    c_n     = c_r;
    sh_n    = sh;
    unique case (state)
      S_IDLE: begin
        if (start && !done) begin
          w_n = pulse_width;
          f_n = freq_sel;
          c_n = pulse_cnt;
          if (send_mask == 3'b000) begin
            mask_n  = 3'b000;
            state_n = S_DONE;
          end else begin
            sh_n    = pick(send_mask, pulse_width,
                           freq_sel, pulse_cnt);
            mask_n  = send_mask & (send_mask - 3'd1);
            state_n = S_START;
          end
        end
      end
      S_START: begin
        if (bit_end) begin
          idx_n   = 3'd0;
          state_n = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (idx == 3'd7) begin
            state_n = S_STOP;
          end else begin
            idx_n = idx + 3'd1;
            sh_n  = {1'b0, sh[7:1]};
          end
        end
      end
      S_STOP: begin
        if (bit_end) begin
          gap_n   = '0;
          state_n = S_GAP;
        end
      end
      S_GAP: begin
        if (bit_end) begin
          if (gap == GW'(GAP_BITS - 1)) begin
            if (mask != 3'b000) begin
              sh_n    = pick(mask, w_r, f_r, c_r);
              mask_n  = mask & (mask - 3'd1);
              state_n = S_START;
            end else begin
              state_n = S_DONE;
            end
          end else begin
            gap_n = gap + GW'(1);
          end
        end
      end
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    // Bit-time counter restarts on every state entry.
    if (state_n != state || bit_end ||
        state == S_IDLE || state == S_DONE)
      cnt_n = '0;
    else
      cnt_n = cnt + CW'(1);

    txd_n  = 1'b1;
    busy_n = 1'b0;
    done_n = 1'b0;
    unique case (state)
      S_START: begin
        txd_n  = 1'b0;
        busy_n = 1'b1;
      end
      S_DATA: begin
        txd_n  = sh[0];
        busy_n = 1'b1;
      end
      S_STOP, S_GAP: busy_n = 1'b1;
      S_DONE: done_n = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      idx      <= '0;
      gap      <= '0;
      mask     <= '0;
      w_r      <= '0;
      f_r      <= '0;
      c_r      <= '0;
      sh       <= '0;
      uart_txd <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      idx      <= idx_n;
      gap      <= gap_n;
      mask     <= mask_n;
      w_r      <= w_n;
      f_r      <= f_n;
      c_r      <= c_n;
      sh       <= sh_n;
      uart_txd <= txd_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

endmodule

// File: tb/tb_spike_cmd_uart_tx.sv
// Bench for spike_cmd_uart_tx: per-cycle line model plus UART
// monitor, directed scenarios followed by randomized sequences.
module tb_spike_cmd_uart_tx;

  localparam int BD    = 10;
  localparam int GB    = 2;
  localparam int FRAME = (10 + GB) * BD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [5:0] pw = '0;
  logic [5:0] fs = '0;
  logic [5:0] pc = '0;
  logic [2:0] mask = '0;
  logic       uart_txd;
  logic       busy;
  logic       done;

  int vecs = 0;
  int errs = 0;
  int cyc = 0;
  int edges = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];

  spike_cmd_uart_tx #(
    .CLK_FREQ(1_000_000),
    .BAUD    (100_000),
    .GAP_BITS(GB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .pulse_width(pw),
    .freq_sel   (fs),
    .pulse_cnt  (pc),
    .send_mask  (mask),
    .uart_txd   (uart_txd),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(uart_txd) edges++;

  // UART receiver: sample mid-bit after each detected start edge.
  initial begin
    logic prev;
    logic [7:0] b;
    prev = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (uart_txd === 1'b0 && prev === 1'b1) begin
        repeat (5) @(posedge clk);
        for (int j = 0; j < 8; j++) begin
          repeat (BD) @(posedge clk);
          #2;
          b[j] = uart_txd;
        end
        repeat (BD) @(posedge clk);
        #2;
        rx_q.push_back(b);
      end
      prev = uart_txd;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Line level s cycles after the first start-bit fall.
  function automatic logic exp_txd(input int s);
    logic [7:0] b;
    int p;
    if (s < 0 || s >= exp_q.size() * FRAME) return 1'b1;
    b = exp_q[s / FRAME];
    p = (s % FRAME) / BD;
    if (p == 0) return 1'b0;
    if (p <= 8) return b[p-1];
    return 1'b1;
  endfunction

  // mode: 0 plain, 1 start+input churn mid-DATA,
  // 2 reset during DATA bit 4, 3 start while done is high.
  task automatic run_seq(input logic [5:0] w,
                         input logic [5:0] f,
                         input logic [5:0] c,
                         input logic [2:0] m,
                         input int mode);
    int k;
    exp_q.delete();
    if (m[0]) exp_q.push_back({2'b01, w});
    if (m[1]) exp_q.push_back({2'b10, f});
    if (m[2]) exp_q.push_back({2'b11, c});
    k = exp_q.size();
    rx_q.delete();
    pw = w;
    fs = f;
    pc = c;
    mask = m;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int s = 0; s <= k * FRAME + 3; s++) begin
      @(posedge clk);
      #1;
      chk("txd", 32'(uart_txd), 32'(exp_txd(s)));
      chk("busy", 32'(busy), 32'(s < k * FRAME));
      chk("done", 32'(done), 32'(s == k * FRAME));
      if (mode == 1 && s == 40) begin
        start = 1'b1;
        pw = 6'($urandom);
        fs = 6'($urandom);
        pc = 6'($urandom);
        mask = 3'b111;
      end
      if (mode == 1 && s == 41) start = 1'b0;
      if (mode == 3 && s == k * FRAME) start = 1'b1;
      if (mode == 3 && s == k * FRAME + 1) start = 1'b0;
      if (mode == 2 && s == 55) begin
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_txd", 32'(uart_txd), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        return;
      end
    end
    chk("rx_count", 32'(rx_q.size()), 32'(k));
    for (int i = 0; i < k && i < rx_q.size(); i++)
      chk("rx_byte", 32'(rx_q[i]), 32'(exp_q[i]));
  endtask

  task automatic idle_check(input int n);
    int e0;
    e0 = edges;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      chk("idle_txd", 32'(uart_txd), 32'd1);
      chk("idle_busy", 32'(busy), 32'd0);
    end
    chk("idle_edges", 32'(edges), 32'(e0));
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("reset_txd", 32'(uart_txd), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    idle_check(100);

    run_seq(6'd5, 6'd7, 6'd3, 3'b111, 0);
    run_seq(6'd0, 6'd12, 6'd0, 3'b010, 0);
    run_seq(6'd63, 6'd0, 6'd0, 3'b001, 0);
    run_seq(6'd5, 6'd7, 6'd3, 3'b111, 1);
    run_seq(6'd1, 6'd2, 6'd3, 3'b000, 0);
    run_seq(6'd9, 6'd4, 6'd2, 3'b101, 3);
    run_seq(6'd0, 6'd0, 6'd0, 3'b000, 3);
    run_seq(6'd11, 6'd22, 6'd33, 3'b110, 0);

    run_seq(6'd5, 6'd7, 6'd3, 3'b111, 2);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_check(100);
    run_seq(6'd0, 6'd0, 6'd9, 3'b100, 0);

    repeat (6)
      run_seq(6'($urandom), 6'($urandom), 6'($urandom),
              3'($urandom_range(0, 7)), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule

// File: doc/spike_cmd_uart_tx.md
# spike_cmd_uart_tx

Host-side command encoder and UART serializer for the spike generator's command link. On a `start` strobe it captures pulse-width, frequency-select and pulse-count values and formats them into opcode-tagged command bytes. It transmits those bytes as 8N1 UART frames on `uart_txd`, in the order the spike generator's receive-side decoder requires. It sits at the initiator end of the serial link, driving the RX pin of the spike generator.

## Interface
Parameters:
- `CLK_FREQ`, 50_000_000, clk frequency in Hz.
- `BAUD`, 115200, line rate; `BAUD_DIV = CLK_FREQ/BAUD` (integer truncation, 434 at defaults). Must be ≥ 2.
- `GAP_BITS`, 2, idle-high bit-times inserted after every stop bit. Must be ≥ 1.

Ports:
- `clk`, in, 1, system clock.
- `rst_n`, in, 1, asynchronous, active-low reset.
- `start`, in, 1, one-cycle request to send a command sequence.
- `pulse_width`, in, 6, width value, sent with opcode `2'b01`.
- `freq_sel`, in, 6, frequency index, sent with opcode `2'b10`.
- `pulse_cnt`, in, 6, burst count, sent with opcode `2'b11`.
- `send_mask`, in, 3, per-byte enable: bit0 = width, bit1 = freq, bit2 = count.
- `uart_txd`, out, 1, serial line; idle high.
- `busy`, out, 1, high while a sequence is in progress.
- `done`, out, 1, one-cycle pulse when a sequence finishes.

## Operation
- **Byte format:** `{opcode[1:0], value[5:0]}`.
- **Send order is fixed:** width, then freq, then count. Count must follow freq because a freq command clears the receiver's count register. Bytes whose mask bit is 0 are skipped.
- **Capture:** `start` is sampled in IDLE only. On acceptance, `pulse_width`, `freq_sel`, `pulse_cnt` and `send_mask` are latched. Later input changes have no effect until the next accepted `start`.
- **Ignored start:** `start` while `busy = 1` is ignored, with no queueing.
- **Empty mask:** `start` with `send_mask = 0` produces no line activity. `done` pulses in the next cycle and `busy` stays 0.
- **FSM states:**
  - IDLE: `txd` = 1. Accepted `start` with nonzero mask → START with the first enabled byte loaded.
  - START: `txd` = 0 for 1 bit-time → DATA.
  - DATA: 8 bits, LSB first, 1 bit-time each; a 3-bit index counts 0..7 → STOP.
  - STOP: `txd` = 1 for 1 bit-time → GAP.
  - GAP: `txd` = 1 for `GAP_BITS` bit-times. If another enabled byte remains, load it → START; otherwise → DONE.
  - DONE: `done` = 1 for one cycle → IDLE.
- **Bit timing:** one bit-time is exactly `BAUD_DIV` clk cycles, counted by a baud counter running `0..BAUD_DIV-1`. The counter is cleared on every state entry.
- **Output register:** `uart_txd` is driven from a flop (glitch-free).

## Timing
- **Reset values:** `uart_txd` = 1, `busy` = 0, `done` = 0. FSM in IDLE, all counters 0.
- **Sequence start:** `start` accepted at edge N → `uart_txd` falls and `busy` rises after edge N+1.
- **Per-byte duration:** `(10 + GAP_BITS) × BAUD_DIV` cycles, measured from the start-bit fall to the next byte's start-bit fall.
- **Completion:** `done` is high for exactly the cycle after the last GAP bit-time ends. `busy` falls in the same cycle `done` rises.
- **Back-to-back:** a `start` sampled in the cycle `done` is high is ignored. `start` is accepted from the following cycle.
- **Total latency:** for k enabled bytes, from the `uart_txd` fall to `done` high is `k × (10 + GAP_BITS) × BAUD_DIV` cycles.
- **Reset mid-operation:** assertion of `rst_n` forces `uart_txd` = 1, `busy` = 0, `done` = 0 immediately (asynchronous). The partial frame is abandoned, with no resumption after release.

## Test plan
Bench parameters: `CLK_FREQ` = 1_000_000, `BAUD` = 100_000 (`BAUD_DIV` = 10), `GAP_BITS` = 2, with a UART monitor on `uart_txd`.

1. **Reset:** hold `rst_n` low for 5 cycles, then release → `uart_txd` = 1, `busy` = 0, `done` = 0, and no edges on `uart_txd` for 100 cycles.
2. **Full sequence:** width = 5, freq = 7, count = 3, mask = 3'b111, `start` at edge N → monitor decodes `0x45`, `0x87`, `0xC3` in order. `done` is high exactly at cycle N+1+360; `busy` is high for exactly 360 cycles.
3. **Single byte:** mask = 3'b010, freq = 12 → single byte `0x8C`. Start-bit low for 10 cycles, stop plus gap high for 30 cycles, `done` 120 cycles after the `txd` fall. With width = 63 and mask = 3'b001 → single byte `0x7F`.
4. **Start while busy:** a second `start` and changed inputs mid-DATA during scenario 2 → same three bytes only, and exactly one `done` pulse.
5. **Empty mask:** mask = 0 with `start` → `done` high in the next cycle, `busy` never high, `uart_txd` constantly 1.
6. **Reset during DATA:** assert `rst_n` low during DATA bit 4 → `uart_txd` = 1 and `busy` = 0 within the same cycle. After release, a new `start` (mask = 3'b100, count = 9) yields a clean `0xC9`.
